// File: rtl/frag_branch_pkg.sv
// Shared constants, FSM state type and predictor helpers for the branch
// resolution unit (frag_branch_resolve) and its optional predictor table.
package frag_branch_pkg;

  // Branch condition encodings carried in ctrl_JorB[2:0]
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside ctrl_JorB
  localparam int CTRL_JUMP = 4;
  localparam int CTRL_BR   = 3;
  localparam int CTRL_JALR = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } resolveState_t;

  // Weakly-not-taken starting point for every predictor entry
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Two-bit saturating counter step
  function automatic logic [1:0] satStep(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != 2'b11)       nxt = cur + 2'b01;
    else if (!taken && cur != 2'b00) nxt = cur - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/frag_bht.sv
// Branch history table: BHT_DEPTH two-bit saturating counters indexed by
// pc[log2(BHT_DEPTH)+1:2]. Combinational lookup, update on the clock edge,
// so a same-index lookup in the update cycle still sees the old entry.
module frag_bht
  import frag_branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rdPc,
  output logic            rdTaken,
  input  logic            updEn,
  input  logic [XLEN-1:0] updPc,
  input  logic            updTaken
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bhtTable [BHT_DEPTH];
  logic [IDX_W-1:0] rdIdx;
  logic [IDX_W-1:0] updIdx;
  logic             unusedPcBits;

  assign rdIdx        = rdPc[IDX_W+1:2];
  assign updIdx       = updPc[IDX_W+1:2];
  assign rdTaken      = bhtTable[rdIdx][1];
  assign unusedPcBits = ^{rdPc[XLEN-1:IDX_W+2], rdPc[1:0], updPc[XLEN-1:IDX_W+2], updPc[1:0]};

  // Counter table: reset to weakly-not-taken, step the addressed entry on update
  // NOTE: the table is small, so every entry is reset explicitly; a larger array would be left unreset and initialised by software instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bhtTable[i] <= BHT_RESET;
    end else if (updEn) begin
      bhtTable[updIdx] <= satStep(bhtTable[updIdx], updTaken);
    end
  end

endmodule

// File: rtl/frag_branch_resolve.sv
// EX-stage branch/jump resolution: operand compare, target and link
// computation, prediction check, registered redirect held under a
// valid/ready handshake, and branch/mispredict counters.
// Optional feature: define FRAG_BHT_EN to build the 2-bit predictor table;
// without it bht_rd_taken is tied low (static not-taken).
module frag_branch_resolve
  import frag_branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl_JorB,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_misalign,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred,
  input  logic [XLEN-1:0]  bht_rd_pc,
  output logic             bht_rd_taken
);

  resolveState_t state;

  logic            isJump;
  logic            isBranch;
  logic            isJalr;
  logic            accept;
  logic            taken;
  logic [XLEN-1:0] linkVal;
  logic [XLEN-1:0] targetSum;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            mispred;
  logic [XLEN-1:0] nextPc;
  logic            issueRedir;

  // A jump wins if both jump and branch bits are set
  assign isJump   = ctrl_JorB[CTRL_JUMP];
  assign isBranch = ctrl_JorB[CTRL_BR] & ~isJump;
  assign isJalr   = isJump & ctrl_JorB[CTRL_JALR];
  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & (isJump | isBranch);

  // Direction from the operand compare; reserved conditions resolve not-taken
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    if (isJump) begin
      taken = 1'b1;
    end else begin
      unique case (ctrl_JorB[2:0])
        F3_BEQ:  taken = (in_rs1 == in_rs2);
        F3_BNE:  taken = (in_rs1 != in_rs2);
        F3_BLT:  taken = ($signed(in_rs1) <  $signed(in_rs2));
        F3_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
        F3_BLTU: taken = (in_rs1 <  in_rs2);
        F3_BGEU: taken = (in_rs1 >= in_rs2);
        default: taken = 1'b0;
      endcase
    end
  end

  // Target, link and prediction check; all sums wrap at 2^XLEN
  assign linkVal    = in_pc + XLEN'(4);
  assign targetSum  = (isJalr ? in_rs1 : in_pc) + in_imm;
  assign target     = isJalr ? {targetSum[XLEN-1:1], 1'b0} : targetSum;
  assign misalign   = taken & (target[1:0] != 2'b00);
  assign mispred    = (taken != in_pred_taken) | (taken & in_pred_taken & (target != in_pred_target));
  assign nextPc     = taken ? target : linkVal;
  // A misaligned taken target goes to the trap path, so fetch is not redirected
  assign issueRedir = accept & mispred & ~misalign;

  // Result registers, redirect FSM and counters
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_misalign <= 1'b0;
      out_link     <= '0;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      cnt_branch   <= '0;
      cnt_mispred  <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_taken    <= taken;
        out_misalign <= misalign;
        out_link     <= linkVal;
        cnt_branch   <= cnt_branch + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (issueRedir) begin
            state       <= REDIRECT;
            redir_valid <= 1'b1;
            redir_pc    <= nextPc;
            cnt_mispred <= cnt_mispred + CNT_W'(1);
          end
        end
        REDIRECT: begin
          if (redir_ready) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAG_BHT_EN
  frag_bht #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdPc     (bht_rd_pc),
    .rdTaken  (bht_rd_taken),
    .updEn    (accept & isBranch),
    .updPc    (in_pc),
    .updTaken (taken)
  );
`else
  logic unusedBhtCfg;
  assign unusedBhtCfg = ^bht_rd_pc ^ BHT_DEPTH[0];
  assign bht_rd_taken = 1'b0;
`endif

endmodule

// File: tb/tb_frag_branch_resolve.sv
// Directed bench for frag_branch_resolve with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_frag_branch_resolve;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       ctrl_JorB;
  logic [XLEN-1:0]  in_pc, in_rs1, in_rs2, in_imm, in_pred_target;
  logic             in_pred_taken;
  logic [XLEN-1:0]  out_link;
  logic             out_valid, out_taken, out_misalign;
  logic             redir_valid, redir_ready;
  logic [XLEN-1:0]  redir_pc;
  logic [CNT_W-1:0] cnt_branch, cnt_mispred;
  logic [XLEN-1:0]  bht_rd_pc;
  logic             bht_rd_taken;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frag_branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W), .BHT_DEPTH(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_JorB      (ctrl_JorB),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .out_link       (out_link),
    .out_valid      (out_valid),
    .out_taken      (out_taken),
    .out_misalign   (out_misalign),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_pc       (redir_pc),
    .cnt_branch     (cnt_branch),
    .cnt_mispred    (cnt_mispred),
    .bht_rd_pc      (bht_rd_pc),
    .bht_rd_taken   (bht_rd_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] ctrl, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic predT, input logic [31:0] predTgt);
    in_valid       = 1'b1;
    ctrl_JorB      = ctrl;
    in_pc          = pc;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_imm         = imm;
    in_pred_taken  = predT;
    in_pred_target = predTgt;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ctrl_JorB = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0; redir_ready = 1'b0; bht_rd_pc = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_redir_valid", 32'(redir_valid), 32'd0);
    check("rst_cnt_branch", cnt_branch, 32'd0);
    check("rst_cnt_mispred", cnt_mispred, 32'd0);
    check("rst_redir_pc", redir_pc, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // BLT signed: -1 < 1 taken, predicted not-taken -> redirect to 0x120
    issue(5'b01100, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
    step(); in_valid = 1'b0;
    check("blt_out_valid", 32'(out_valid), 32'd1);
    check("blt_taken", 32'(out_taken), 32'd1);
    check("blt_link", out_link, 32'h104);
    check("blt_redir_valid", 32'(redir_valid), 32'd1);
    check("blt_redir_pc", redir_pc, 32'h120);
    check("blt_cnt_mispred", cnt_mispred, 32'd1);
    check("blt_cnt_branch", cnt_branch, 32'd1);
    check("blt_in_ready", 32'(in_ready), 32'd0);
    redir_ready = 1'b1;
    step(); redir_ready = 1'b0;
    check("blt_release_redir", 32'(redir_valid), 32'd0);
    check("blt_release_ready", 32'(in_ready), 32'd1);
    check("blt_pulse_end", 32'(out_valid), 32'd0);

    // BLTU same operands: 0xFFFFFFFF < 1 unsigned is false -> not taken, correct
    issue(5'b01110, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
    step(); in_valid = 1'b0;
    check("bltu_out_valid", 32'(out_valid), 32'd1);
    check("bltu_taken", 32'(out_taken), 32'd0);
    check("bltu_redir_valid", 32'(redir_valid), 32'd0);
    check("bltu_cnt_branch", cnt_branch, 32'd2);
    check("bltu_cnt_mispred", cnt_mispred, 32'd1);

    // JALR rs1=0x1003 imm=0 -> target 0x1002, misaligned, redirect suppressed
    issue(5'b10001, 32'h200, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1000);
    step(); in_valid = 1'b0;
    check("jalr_taken", 32'(out_taken), 32'd1);
    check("jalr_misalign", 32'(out_misalign), 32'd1);
    check("jalr_redir_valid", 32'(redir_valid), 32'd0);
    check("jalr_link", out_link, 32'h204);
    check("jalr_cnt_branch", cnt_branch, 32'd3);
    check("jalr_cnt_mispred", cnt_mispred, 32'd1);

    // Non-branch control value is ignored
    issue(5'b00000, 32'h280, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(); in_valid = 1'b0;
    check("nop_out_valid", 32'(out_valid), 32'd0);
    check("nop_cnt_branch", cnt_branch, 32'd3);

    // JAL correctly predicted -> no redirect, aligned
    issue(5'b10000, 32'h300, 32'h0, 32'h0, 32'h40, 1'b1, 32'h340);
    step(); in_valid = 1'b0;
    check("jal_out_valid", 32'(out_valid), 32'd1);
    check("jal_misalign", 32'(out_misalign), 32'd0);
    check("jal_redir_valid", 32'(redir_valid), 32'd0);
    check("jal_cnt_branch", cnt_branch, 32'd4);

    // BEQ with wrap-around target 0x4 + (-8) = 0xFFFFFFFC, then hold redirect
    issue(5'b01000, 32'h4, 32'h5, 32'h5, 32'hFFFF_FFF8, 1'b0, 32'h0);
    step();
    check("beq_redir_valid", 32'(redir_valid), 32'd1);
    check("beq_redir_pc", redir_pc, 32'hFFFF_FFFC);
    check("beq_cnt_mispred", cnt_mispred, 32'd2);
    check("beq_cnt_branch", cnt_branch, 32'd5);
    // Next instruction (BNE, taken, correctly predicted) waits behind the redirect
    issue(5'b01001, 32'h500, 32'h1, 32'h2, 32'h10, 1'b1, 32'h510);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_redir_valid", 32'(redir_valid), 32'd1);
      check("hold_redir_pc", redir_pc, 32'hFFFF_FFFC);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_cnt_branch", cnt_branch, 32'd5);
      check("hold_out_valid", 32'(out_valid), 32'd0);
    end
    redir_ready = 1'b1;
    step(); redir_ready = 1'b0;
    check("hs_redir_valid", 32'(redir_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_cnt_branch", cnt_branch, 32'd5);
    step(); in_valid = 1'b0;
    check("bne_out_valid", 32'(out_valid), 32'd1);
    check("bne_taken", 32'(out_taken), 32'd1);
    check("bne_link", out_link, 32'h504);
    check("bne_redir_valid", 32'(redir_valid), 32'd0);
    check("bne_cnt_branch", cnt_branch, 32'd6);

    // Reserved funct3 predicted taken -> resolves not taken, redirect to pc+4
    issue(5'b01010, 32'h600, 32'h0, 32'h0, 32'h100, 1'b1, 32'h700);
    step(); in_valid = 1'b0;
    check("rsv_taken", 32'(out_taken), 32'd0);
    check("rsv_redir_valid", 32'(redir_valid), 32'd1);
    check("rsv_redir_pc", redir_pc, 32'h604);
    check("rsv_cnt_mispred", cnt_mispred, 32'd3);
    check("rsv_cnt_branch", cnt_branch, 32'd7);

    // Reset while the redirect is pending
    #2 rst_n = 1'b0;
    #1;
    check("midrst_redir_valid", 32'(redir_valid), 32'd0);
    check("midrst_cnt_branch", cnt_branch, 32'd0);
    check("midrst_cnt_mispred", cnt_mispred, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_redir_after", 32'(redir_valid), 32'd0);

    // BGE signed: 0x80000000 >= 0 is false -> not taken, correct
    issue(5'b01101, 32'h700, 32'h8000_0000, 32'h0, 32'h8, 1'b0, 32'h0);
    step(); in_valid = 1'b0;
    check("bge_taken", 32'(out_taken), 32'd0);
    check("bge_redir_valid", 32'(redir_valid), 32'd0);
    check("bge_cnt_branch", cnt_branch, 32'd1);

`ifdef FRAG_BHT_EN
    // Three taken BEQs at pc 0x40: entry 01 -> 10 -> 11 -> 11
    bht_rd_pc = 32'h40;
    #1;
    check("bht_init", 32'(bht_rd_taken), 32'd0);
    for (int i = 0; i < 3; i++) begin
      issue(5'b01000, 32'h40, 32'h7, 32'h7, 32'h10, 1'b1, 32'h50);
      step(); in_valid = 1'b0;
      check("bht_taken", 32'(bht_rd_taken), 32'd1);
      check("bht_redir_valid", 32'(redir_valid), 32'd0);
    end
`else
    bht_rd_pc = 32'h40;
    #1;
    check("bht_static", 32'(bht_rd_taken), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
